// File: rtl/hold_gen_multi.sv
// Multi-trigger hold generator: synchronises active-low triggers, forms a coincidence event,
// and drives a delayed HOLD pulse with dead time plus an independent delayed RAZ enable pulse.
module hold_gen_multi #(
    parameter int N_TRIG      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DELAY_W     = 10,
    parameter int WIDTH_W     = 16,
    parameter int WIN_W       = 8
) (
    input  logic               Clk,
    input  logic               reset_n,
    input  logic               Hold_en,
    input  logic [N_TRIG-1:0]  TRIGB,
    input  logic [N_TRIG-1:0]  TrigMask,
    input  logic [1:0]         CoincMode,
    input  logic [2:0]         TrigSel,
    input  logic [3:0]         CoincThresh,
    input  logic [WIN_W-1:0]   CoincWindow,
    input  logic [DELAY_W-1:0] HoldDelay,
    input  logic [WIDTH_W-1:0] HoldWidth,
    input  logic [WIDTH_W-1:0] DeadTime,
    input  logic               CntClr,
    output logic               HOLD,
    output logic               HoldBusy,
    output logic [15:0]        HoldCount,
    output logic [15:0]        TrigLost,
    input  logic               ExternalRaz_en,
    input  logic [DELAY_W-1:0] RazDelay,
    input  logic [WIDTH_W-1:0] RazWidth,
    output logic               SingleRaz_en
);
    localparam int CW = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

    localparam logic [1:0] H_IDLE  = 2'd0;
    localparam logic [1:0] H_DELAY = 2'd1;
    localparam logic [1:0] H_HOLD  = 2'd2;
    localparam logic [1:0] H_DEAD  = 2'd3;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_DLY  = 2'd1;
    localparam logic [1:0] R_ACT  = 2'd2;

    logic [SYNC_STAGES-1:0][N_TRIG-1:0] sync_ff;
    logic [N_TRIG-1:0]                  prev, fall, act, mfall, mact;
    logic [N_TRIG-1:0][WIN_W-1:0]       win;
    logic [3:0]                         pop, thr;
    logic                               sel_fall, trig_evt, accept, lost, hold_rise;
    logic [1:0]                         hstate, rstate;
    logic [CW-1:0]                      hcnt, rcnt;
    logic [CW-1:0]                      hd_lim, hw_lim, dt_lim, rd_lim, rw_lim;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= '1;
            prev    <= '1;
        end else begin
            sync_ff[0] <= TRIGB;
            for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
            prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign fall  = prev & ~sync_ff[SYNC_STAGES-1];
    assign mfall = fall & TrigMask;
    assign mact  = act & TrigMask;

    always_comb begin
        act      = '0;
        pop      = '0;
        sel_fall = 1'b0;
        for (int i = 0; i < N_TRIG; i++) begin
            act[i] = fall[i] | (win[i] != '0);
            pop    = pop + 4'(mact[i]);
            if (TrigSel == 3'(i)) sel_fall = fall[i];
        end
        thr = (CoincThresh == 4'd0) ? 4'd1 : CoincThresh;
        case (CoincMode)
            2'b00:   trig_evt = sel_fall;
            2'b01:   trig_evt = |mfall;
            2'b10:   trig_evt = (|TrigMask) && (&(act | ~TrigMask)) && (|mfall);
            default: trig_evt = (pop >= thr) && (|mfall);
        endcase
    end

    assign accept    = trig_evt && Hold_en && (hstate == H_IDLE);
    assign lost      = trig_evt && ((hstate != H_IDLE) || !Hold_en);
    assign hold_rise = (hstate == H_DELAY) && (hcnt == hd_lim);
    assign HoldBusy  = (hstate != H_IDLE);

    // Terminal counts are "last cycle" values so a zero width still yields one cycle.
    assign hd_lim = CW'(HoldDelay);
    assign hw_lim = (HoldWidth == '0) ? '0 : CW'(HoldWidth - WIDTH_W'(1));
    assign dt_lim = CW'(DeadTime - WIDTH_W'(1));
    assign rd_lim = (RazDelay == '0) ? '0 : CW'(RazDelay - DELAY_W'(1));
    assign rw_lim = (RazWidth == '0) ? '0 : CW'(RazWidth - WIDTH_W'(1));

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            win <= '0;
        end else begin
            for (int i = 0; i < N_TRIG; i++) begin
                if (accept)              win[i] <= '0;
                else if (fall[i])        win[i] <= CoincWindow;
                else if (win[i] != '0)   win[i] <= win[i] - WIN_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            hstate    <= H_IDLE;
            hcnt      <= '0;
            HOLD      <= 1'b0;
            HoldCount <= '0;
            TrigLost  <= '0;
        end else begin
            case (hstate)
                H_IDLE: if (accept) begin
                    hstate <= H_DELAY;
                    hcnt   <= '0;
                end
                H_DELAY: if (hcnt == hd_lim) begin
                    HOLD   <= 1'b1;
                    hcnt   <= '0;
                    hstate <= H_HOLD;
                end else hcnt <= hcnt + CW'(1);
                H_HOLD: if (hcnt == hw_lim) begin
                    HOLD   <= 1'b0;
                    hcnt   <= '0;
                    hstate <= (DeadTime == '0) ? H_IDLE : H_DEAD;
                end else hcnt <= hcnt + CW'(1);
                default: if (hcnt == dt_lim) begin
                    hcnt   <= '0;
                    hstate <= H_IDLE;
                end else hcnt <= hcnt + CW'(1);
            endcase
            if (CntClr) begin
                HoldCount <= '0;
                TrigLost  <= '0;
            end else begin
                if (hold_rise) HoldCount <= HoldCount + 16'd1;
                if (lost && TrigLost != 16'hFFFF) TrigLost <= TrigLost + 16'd1;
            end
        end
    end

    // RAZ path ignores Hold_en; dropping ExternalRaz_en aborts it on the next edge.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            rstate       <= R_IDLE;
            rcnt         <= '0;
            SingleRaz_en <= 1'b0;
        end else if (!ExternalRaz_en) begin
            rstate       <= R_IDLE;
            rcnt         <= '0;
            SingleRaz_en <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: if (|mfall) begin
                    rstate <= R_DLY;
                    rcnt   <= '0;
                end
                R_DLY: if (rcnt == rd_lim) begin
                    rstate       <= R_ACT;
                    SingleRaz_en <= 1'b1;
                    rcnt         <= '0;
                end else rcnt <= rcnt + CW'(1);
                R_ACT: if (rcnt == rw_lim) begin
                    rstate       <= R_IDLE;
                    SingleRaz_en <= 1'b0;
                    rcnt         <= '0;
                end else rcnt <= rcnt + CW'(1);
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hold_gen_multi.sv
// Bench for hold_gen_multi: randomized trigger scenarios checked against arithmetic
// predictions of HOLD/RAZ timing, coincidence outcomes and counter values.
module tb_hold_gen_multi;
    localparam int SYNC = 2;

    logic        Clk = 1'b0;
    logic        reset_n, Hold_en, CntClr, ExternalRaz_en;
    logic [3:0]  TRIGB, TrigMask, CoincThresh;
    logic [1:0]  CoincMode;
    logic [2:0]  TrigSel;
    logic [7:0]  CoincWindow;
    logic [9:0]  HoldDelay, RazDelay;
    logic [15:0] HoldWidth, DeadTime, RazWidth;
    logic        HOLD, HoldBusy, SingleRaz_en;
    logic [15:0] HoldCount, TrigLost;

    int n_checks = 0, n_pass = 0;
    int cyc = 0, rises = 0;
    logic hold_prev = 1'b0;

    hold_gen_multi dut (
        .Clk(Clk), .reset_n(reset_n), .Hold_en(Hold_en), .TRIGB(TRIGB), .TrigMask(TrigMask),
        .CoincMode(CoincMode), .TrigSel(TrigSel), .CoincThresh(CoincThresh),
        .CoincWindow(CoincWindow), .HoldDelay(HoldDelay), .HoldWidth(HoldWidth),
        .DeadTime(DeadTime), .CntClr(CntClr), .HOLD(HOLD), .HoldBusy(HoldBusy),
        .HoldCount(HoldCount), .TrigLost(TrigLost), .ExternalRaz_en(ExternalRaz_en),
        .RazDelay(RazDelay), .RazWidth(RazWidth), .SingleRaz_en(SingleRaz_en)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;
    always @(negedge Clk) begin
        if (HOLD && !hold_prev) rises++;
        hold_prev = HOLD;
    end

    // Observe HOLD (raz=0) or SingleRaz_en (raz=1): k=0 is the state after the first edge.
    task automatic measure(input bit raz, input int budget, output int rise, output int width);
        logic v;
        rise = -1; width = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge Clk);
            v = raz ? SingleRaz_en : HOLD;
            if (v && rise < 0) rise = k;
            if (rise >= 0) begin
                if (v) width++;
                else break;
            end
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge Clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; Hold_en = 1'b1; CntClr = 1'b0; ExternalRaz_en = 1'b1;
        TRIGB = '1; TrigMask = '1; CoincMode = 2'b01; TrigSel = 3'd0; CoincThresh = 4'd1;
        CoincWindow = 8'd5; HoldDelay = 10'd2; HoldWidth = 16'd3; DeadTime = 16'd0;
        RazDelay = 10'd2; RazWidth = 16'd2;
        repeat (3) @(negedge Clk);
        n_checks++; if (HOLD !== 1'b0) $display("FAIL reset_hold: got %b expected 0", HOLD); else n_pass++;
        n_checks++; if (HoldBusy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", HoldBusy); else n_pass++;
        n_checks++; if (SingleRaz_en !== 1'b0) $display("FAIL reset_raz: got %b expected 0", SingleRaz_en); else n_pass++;
        n_checks++; if (HoldCount !== 16'd0) $display("FAIL reset_holdcount: got %0d expected 0", HoldCount); else n_pass++;
        n_checks++; if (TrigLost !== 16'd0) $display("FAIL reset_triglost: got %0d expected 0", TrigLost); else n_pass++;
        reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        ExternalRaz_en = 1'b0;
    endtask

    task automatic test_single;
        int d, w, sel, rise, width, hc0;
        for (int t = 0; t < 4; t++) begin
            if (t == 0) begin d = 10; w = 3200; sel = 1; end
            else begin d = $urandom_range(0, 30); w = $urandom_range(0, 40); sel = $urandom_range(0, 3); end
            @(negedge Clk);
            CoincMode = 2'b00; TrigSel = 3'(sel); HoldDelay = 10'(d); HoldWidth = 16'(w); DeadTime = '0;
            hc0 = int'(HoldCount);
            TRIGB[sel] = 1'b0;
            measure(0, d + w + 40, rise, width);
            TRIGB = '1;
            n_checks++; if (rise !== SYNC + d + 1) $display("FAIL single_latency: got %0d expected %0d (d=%0d)", rise, SYNC + d + 1, d); else n_pass++;
            n_checks++; if (width !== ((w == 0) ? 1 : w)) $display("FAIL single_width: got %0d expected %0d", width, (w == 0) ? 1 : w); else n_pass++;
            n_checks++; if (HoldCount !== 16'(hc0 + 1)) $display("FAIL single_count: got %0d expected %0d", HoldCount, hc0 + 1); else n_pass++;
            repeat (5) @(negedge Clk);
        end
        @(negedge Clk);
        TrigSel = 3'd5; HoldDelay = 10'd1; HoldWidth = 16'd2;
        TRIGB = '0;
        measure(0, 40, rise, width);
        TRIGB = '1;
        n_checks++; if (rise !== -1) $display("FAIL single_sel_oob: got rise %0d expected none", rise); else n_pass++;
        repeat (5) @(negedge Clk);
    endtask

    task automatic test_or;
        int ch, rise, width;
        logic [3:0] mask;
        HoldDelay = 10'd1; HoldWidth = 16'd4; CoincMode = 2'b01;
        for (int t = 0; t < 6; t++) begin
            mask = 4'($urandom);
            ch = $urandom_range(0, 3);
            @(negedge Clk);
            TrigMask = mask;
            TRIGB[ch] = 1'b0;
            measure(0, 30, rise, width);
            TRIGB = '1;
            n_checks++;
            if ((rise >= 0) !== mask[ch]) $display("FAIL or_mask: got hold=%0d expected %0d (mask=%b ch=%0d)", rise >= 0, mask[ch], mask, ch);
            else n_pass++;
            repeat (3) @(negedge Clk);
        end
    endtask

    task automatic test_and;
        int win, gap, rise, width;
        bit hit;
        HoldDelay = 10'd2; HoldWidth = 16'd3; CoincMode = 2'b10; TrigMask = 4'b0011;
        for (int t = 0; t < 7; t++) begin
            if (t == 0) begin win = 5; gap = 4; end
            else if (t == 1) begin win = 5; gap = 7; end
            else begin win = $urandom_range(1, 10); gap = $urandom_range(0, 12); end
            hit = (gap <= win);
            @(negedge Clk);
            CoincWindow = 8'(win);
            TRIGB[0] = 1'b0;
            repeat (gap) @(negedge Clk);
            TRIGB[1] = 1'b0;
            measure(0, 40, rise, width);
            TRIGB = '1;
            n_checks++;
            if ((rise >= 0) !== hit) $display("FAIL and_window: got hold=%0d expected %0d (win=%0d gap=%0d)", rise >= 0, hit, win, gap);
            else n_pass++;
            repeat (5) @(negedge Clk);
        end
    endtask

    task automatic test_majority;
        int thr, n, start, rise, width;
        bit hit;
        HoldDelay = 10'd2; HoldWidth = 16'd3; CoincMode = 2'b11; TrigMask = 4'b1111; CoincWindow = 8'd8;
        for (int t = 0; t < 7; t++) begin
            if (t == 0) begin thr = 3; n = 3; end
            else if (t == 1) begin thr = 3; n = 2; end
            else if (t == 2) begin thr = 0; n = 1; end
            else begin thr = $urandom_range(0, 5); n = $urandom_range(1, 4); end
            hit = (n >= ((thr == 0) ? 1 : thr));
            start = $urandom_range(0, 3);
            @(negedge Clk);
            CoincThresh = 4'(thr);
            for (int j = 0; j < n; j++) begin
                TRIGB[(start + j) % 4] = 1'b0;
                @(negedge Clk);
            end
            measure(0, 30, rise, width);
            TRIGB = '1;
            n_checks++;
            if ((rise >= 0) !== hit) $display("FAIL majority: got hold=%0d expected %0d (thr=%0d n=%0d)", rise >= 0, hit, thr, n);
            else n_pass++;
            repeat (12) @(negedge Clk);
        end
    endtask

    task automatic test_dead_time;
        int base, t1, t2, r0, k;
        @(negedge Clk);
        CoincMode = 2'b01; TrigMask = 4'b1111; HoldDelay = 10'd4; HoldWidth = 16'd30; DeadTime = 16'd100;
        CntClr = 1'b1;
        @(negedge Clk);
        CntClr = 1'b0;
        r0 = rises;
        t1 = $urandom_range(12, 25);
        t2 = $urandom_range(45, 110);
        base = cyc;
        TRIGB[0] = 1'b0;
        wait_until(base + 3);  TRIGB[0] = 1'b1;
        wait_until(base + t1); TRIGB[1] = 1'b0;
        wait_until(base + t1 + 3); TRIGB[1] = 1'b1;
        wait_until(base + t2);
        n_checks++; if (HoldBusy !== 1'b1 || HOLD !== 1'b0) $display("FAIL dead_busy: got busy=%b hold=%b expected busy=1 hold=0", HoldBusy, HOLD); else n_pass++;
        TRIGB[2] = 1'b0;
        wait_until(base + t2 + 3); TRIGB[2] = 1'b1;
        wait_until(base + 160);
        TRIGB[3] = 1'b0;
        wait_until(base + 163); TRIGB[3] = 1'b1;
        k = 0;
        while (HoldBusy && k < 400) begin @(negedge Clk); k++; end
        n_checks++; if (HoldBusy !== 1'b0) $display("FAIL dead_timeout: got busy=%b expected 0", HoldBusy); else n_pass++;
        n_checks++; if (HoldCount !== 16'd2) $display("FAIL dead_holdcount: got %0d expected 2", HoldCount); else n_pass++;
        n_checks++; if (TrigLost !== 16'd2) $display("FAIL dead_triglost: got %0d expected 2", TrigLost); else n_pass++;
        n_checks++; if (rises - r0 !== 2) $display("FAIL dead_rises: got %0d expected 2", rises - r0); else n_pass++;
        DeadTime = 16'd0;
    endtask

    task automatic test_lost_clr;
        int tl0, hc0;
        @(negedge Clk);
        Hold_en = 1'b0; CoincMode = 2'b01; TrigMask = 4'b1111; HoldDelay = 10'd1; HoldWidth = 16'd2;
        tl0 = int'(TrigLost); hc0 = int'(HoldCount);
        TRIGB[0] = 1'b0;
        repeat (3) @(negedge Clk);
        TRIGB[0] = 1'b1;
        repeat (8) @(negedge Clk);
        n_checks++; if (TrigLost !== 16'(tl0 + 1)) $display("FAIL disabled_lost: got %0d expected %0d", TrigLost, tl0 + 1); else n_pass++;
        n_checks++; if (HoldCount !== 16'(hc0) || HoldBusy !== 1'b0) $display("FAIL disabled_nohold: got count=%0d busy=%b expected %0d/0", HoldCount, HoldBusy, hc0); else n_pass++;
        CntClr = 1'b1;
        TRIGB[1] = 1'b0;
        repeat (3) @(negedge Clk);
        TRIGB[1] = 1'b1;
        repeat (5) @(negedge Clk);
        CntClr = 1'b0;
        @(negedge Clk);
        n_checks++; if (TrigLost !== 16'd0 || HoldCount !== 16'd0) $display("FAIL cntclr_priority: got lost=%0d count=%0d expected 0/0", TrigLost, HoldCount); else n_pass++;
        Hold_en = 1'b1;
    endtask

    task automatic test_raz;
        int d, w, ch, rise, width, k;
        logic [3:0] mask;
        @(negedge Clk);
        Hold_en = 1'b0; ExternalRaz_en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            if (t == 0) begin d = 20; w = 16; end
            else begin d = $urandom_range(0, 30); w = $urandom_range(0, 20); end
            mask = 4'($urandom_range(1, 15));
            ch = $urandom_range(0, 3);
            while (!mask[ch]) ch = (ch + 1) % 4;
            @(negedge Clk);
            RazDelay = 10'(d); RazWidth = 16'(w); TrigMask = mask;
            TRIGB[ch] = 1'b0;
            measure(1, d + w + 40, rise, width);
            TRIGB = '1;
            n_checks++; if (rise !== SYNC + ((d == 0) ? 1 : d)) $display("FAIL raz_delay: got %0d expected %0d", rise, SYNC + ((d == 0) ? 1 : d)); else n_pass++;
            n_checks++; if (width !== ((w == 0) ? 1 : w)) $display("FAIL raz_width: got %0d expected %0d", width, (w == 0) ? 1 : w); else n_pass++;
            repeat (4) @(negedge Clk);
        end
        @(negedge Clk);
        TrigMask = 4'b0001;
        TRIGB[2] = 1'b0;
        measure(1, 40, rise, width);
        TRIGB = '1;
        n_checks++; if (rise !== -1) $display("FAIL raz_unmasked: got rise %0d expected none", rise); else n_pass++;
        @(negedge Clk);
        TrigMask = 4'b1111; RazDelay = 10'd5; RazWidth = 16'd40;
        TRIGB[0] = 1'b0;
        k = 0;
        while (!SingleRaz_en && k < 30) begin @(negedge Clk); k++; end
        n_checks++; if (SingleRaz_en !== 1'b1) $display("FAIL raz_abort_start: got %b expected 1", SingleRaz_en); else n_pass++;
        repeat (3) @(negedge Clk);
        ExternalRaz_en = 1'b0;
        @(negedge Clk);
        n_checks++; if (SingleRaz_en !== 1'b0) $display("FAIL raz_abort: got %b expected 0", SingleRaz_en); else n_pass++;
        TRIGB = '1;
        Hold_en = 1'b1;
        repeat (5) @(negedge Clk);
    endtask

    task automatic test_reset_mid;
        int rise, width, k;
        @(negedge Clk);
        CoincMode = 2'b01; TrigMask = 4'b1111; HoldDelay = 10'd20; HoldWidth = 16'd50; DeadTime = 16'd0;
        TRIGB[0] = 1'b0;
        repeat (3) @(negedge Clk);
        TRIGB[0] = 1'b1;
        repeat (3) @(negedge Clk);
        n_checks++; if (HoldBusy !== 1'b1) $display("FAIL rstmid_delay_busy: got %b expected 1", HoldBusy); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (HOLD !== 1'b0 || HoldBusy !== 1'b0) $display("FAIL rstmid_delay: got hold=%b busy=%b expected 0/0", HOLD, HoldBusy); else n_pass++;
        @(negedge Clk);
        reset_n = 1'b1;
        measure(0, 80, rise, width);
        n_checks++; if (rise !== -1) $display("FAIL rstmid_delay_nohold: got rise %0d expected none", rise); else n_pass++;
        TRIGB[1] = 1'b0;
        repeat (3) @(negedge Clk);
        TRIGB[1] = 1'b1;
        k = 0;
        while (!HOLD && k < 40) begin @(negedge Clk); k++; end
        n_checks++; if (HOLD !== 1'b1) $display("FAIL rstmid_hold_start: got %b expected 1", HOLD); else n_pass++;
        repeat (5) @(negedge Clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (HOLD !== 1'b0) $display("FAIL rstmid_hold: got %b expected 0", HOLD); else n_pass++;
        @(negedge Clk);
        reset_n = 1'b1;
        measure(0, 80, rise, width);
        n_checks++; if (rise !== -1) $display("FAIL rstmid_hold_nohold: got rise %0d expected none", rise); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_or;
        test_and;
        test_majority;
        test_dead_time;
        test_lost_clr;
        test_raz;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
